pad_alsaqr_io_ctrl: RTL and testbench

- Core-side controller for a bank of N_PADS bidirectional pads. It drives the pad control pins (OEN, I, PUEN, DRV, SLW, SMT) and captures each pad's O return.
- A per-pad direction state machine enforces bus turnaround cycles, so a pad never drives while it is still settling from input mode.
- The input path synchronizes, glitch-filters and edge-detects each pad's O signal. The block sits between the GPIO/peripheral register file and the pad frame.

---
 rtl/pad_alsaqr_io_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pad_alsaqr_io_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_alsaqr_io_ctrl.sv
// Core-side controller for a bank of bidirectional pads: per-pad direction FSM with
// turnaround dead cycles, registered pad config, and a synchronized/filtered input path.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IN       | pad released (oen=1), input path valid
//   TURN_OUT | dead cycles before driving, data pre-loaded, abortable
//   OUT      | pad driven (oen=0), direction acknowledged
//   TURN_IN  | dead cycles after releasing, always runs to completion
module pad_alsaqr_io_ctrl #(
    parameter int N_PADS      = 8,
    parameter int TURN_CYCLES = 2,
    parameter int FILT_CYCLES = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_PADS-1:0]     dir_req_i,
    input  logic [N_PADS-1:0]     out_val_i,
    input  logic [N_PADS-1:0]     cfg_puen_i,
    input  logic [2*N_PADS-1:0]   cfg_drv_i,
    input  logic [N_PADS-1:0]     cfg_slw_i,
    input  logic [N_PADS-1:0]     cfg_smt_i,
    output logic [N_PADS-1:0]     pad_oen_o,
    output logic [N_PADS-1:0]     pad_i_o,
    input  logic [N_PADS-1:0]     pad_o_i,
    output logic [N_PADS-1:0]     pad_puen_o,
    output logic [2*N_PADS-1:0]   pad_drv_o,
    output logic [N_PADS-1:0]     pad_slw_o,
    output logic [N_PADS-1:0]     pad_smt_o,
    output logic [N_PADS-1:0]     in_val_o,
    output logic [N_PADS-1:0]     in_valid_o,
    output logic [N_PADS-1:0]     rise_o,
    output logic [N_PADS-1:0]     fall_o,
    output logic [N_PADS-1:0]     dir_ack_o
);

    localparam int TC_W     = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam int FILT_EFF = (FILT_CYCLES > 1) ? FILT_CYCLES : 1;
    localparam int FC_W     = (FILT_EFF > 1) ? $clog2(FILT_EFF) : 1;

    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TURN_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_EFF - 1);

    typedef enum logic [1:0] {
        ST_IN       = 2'd0,
        ST_TURN_OUT = 2'd1,
        ST_OUT      = 2'd2,
        ST_TURN_IN  = 2'd3
    } state_e;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_puen_o <= '0;
            pad_drv_o  <= '0;
            pad_slw_o  <= '0;
            pad_smt_o  <= '0;
        end else begin
            pad_puen_o <= cfg_puen_i;
            pad_drv_o  <= cfg_drv_i;
            pad_slw_o  <= cfg_slw_i;
            pad_smt_o  <= cfg_smt_i;
        end
    end

    for (genvar p = 0; p < N_PADS; p++) begin : g_pad
        state_e          state_q, state_d;
        logic [TC_W-1:0] tc_q, tc_d;
        logic            pad_i_q;
        logic            s1_q, s2_q;
        logic            in_val_q;
        logic [FC_W-1:0] fc_q;
        logic            rise_q, fall_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_IN;
                tc_q    <= '0;
            end else begin
                state_q <= state_d;
                tc_q    <= tc_d;
            end
        end

        always_comb begin
            state_d = state_q;
            tc_d    = tc_q;
            unique case (state_q)
                ST_IN: begin
                    if (dir_req_i[p]) begin
                        tc_d    = '0;
                        state_d = (TURN_CYCLES == 0) ? ST_OUT : ST_TURN_OUT;
                    end
                end
                ST_TURN_OUT: begin
                    if (!dir_req_i[p]) begin
                        tc_d    = '0;
                        state_d = ST_IN;
                    end else if (tc_q == TC_LAST) begin
                        tc_d    = '0;
                        state_d = ST_OUT;
                    end else begin
                        tc_d = tc_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (!dir_req_i[p]) begin
                        tc_d    = '0;
                        state_d = (TURN_CYCLES == 0) ? ST_IN : ST_TURN_IN;
                    end
                end
                ST_TURN_IN: begin
                    if (tc_q == TC_LAST) begin
                        tc_d    = '0;
                        state_d = ST_IN;
                    end else begin
                        tc_d = tc_q + 1'b1;
                    end
                end
                default: begin
                    tc_d    = '0;
                    state_d = ST_IN;
                end
            endcase
        end

        // Data is loaded on the edge that enters TURN_OUT so the pad sees a settled
        // value before OEN drops; it then tracks out_val_i while driving.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                pad_i_q <= 1'b0;
            end else if (state_d == ST_TURN_OUT || state_d == ST_OUT) begin
                pad_i_q <= out_val_i[p];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                in_val_q <= 1'b0;
                fc_q     <= '0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                s1_q   <= pad_o_i[p];
                s2_q   <= s1_q;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s2_q == in_val_q) begin
                    fc_q <= '0;
                end else if (fc_q == FC_LAST) begin
                    fc_q     <= '0;
                    in_val_q <= s2_q;
                    rise_q   <= s2_q;
                    fall_q   <= !s2_q;
                end else begin
                    fc_q <= fc_q + 1'b1;
                end
            end
        end

        assign pad_oen_o[p]  = (state_q != ST_OUT);
        assign pad_i_o[p]    = pad_i_q;
        assign in_val_o[p]   = in_val_q;
        assign in_valid_o[p] = (state_q == ST_IN);
        assign dir_ack_o[p]  = (state_q == ST_OUT);
        // Filter runs in every state; only the edge reporting is tied to IN.
        assign rise_o[p]     = rise_q && (state_q == ST_IN);
        assign fall_o[p]     = fall_q && (state_q == ST_IN);
    end

endmodule

// File: tb/tb_pad_alsaqr_io_ctrl.sv
// Self-checking bench for pad_alsaqr_io_ctrl with default parameters
// (8 pads, 2 turnaround cycles, 3-cycle input filter).
module tb_pad_alsaqr_io_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  dir_req_i, out_val_i, cfg_puen_i, cfg_slw_i, cfg_smt_i, pad_o_i;
    logic [15:0] cfg_drv_i;
    logic [7:0]  pad_oen_o, pad_i_o, pad_puen_o, pad_slw_o, pad_smt_o;
    logic [15:0] pad_drv_o;
    logic [7:0]  in_val_o, in_valid_o, rise_o, fall_o, dir_ack_o;

    pad_alsaqr_io_ctrl #(.N_PADS(8), .TURN_CYCLES(2), .FILT_CYCLES(3)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .dir_req_i  (dir_req_i),
        .out_val_i  (out_val_i),
        .cfg_puen_i (cfg_puen_i),
        .cfg_drv_i  (cfg_drv_i),
        .cfg_slw_i  (cfg_slw_i),
        .cfg_smt_i  (cfg_smt_i),
        .pad_oen_o  (pad_oen_o),
        .pad_i_o    (pad_i_o),
        .pad_o_i    (pad_o_i),
        .pad_puen_o (pad_puen_o),
        .pad_drv_o  (pad_drv_o),
        .pad_slw_o  (pad_slw_o),
        .pad_smt_o  (pad_smt_o),
        .in_val_o   (in_val_o),
        .in_valid_o (in_valid_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .dir_ack_o  (dir_ack_o)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic [7:0] dir;
        logic [7:0] val;
        logic [7:0] oen;
        logic [7:0] pi;
        logic       chk_pi;
        logic [7:0] valid;
        logic [7:0] ack;
    } vec_t;

    function automatic vec_t mk(bit d, bit v, bit oen0, bit pi0, bit chk, bit valid0, bit ack0);
        vec_t r;
        r.dir    = {7'h00, d};
        r.val    = {7'h00, v};
        r.oen    = {7'h7F, oen0};
        r.pi     = {7'h00, pi0};
        r.chk_pi = chk;
        r.valid  = {7'h7F, valid0};
        r.ack    = {7'h00, ack0};
        return r;
    endfunction

    typedef struct {
        logic [7:0]  puen;
        logic [15:0] drv;
        logic [7:0]  slw;
        logic [7:0]  smt;
    } cfg_t;

    cfg_t sb_q[$];
    vec_t vecs[16];

    initial begin
        cfg_t c, e;
        bit   any;

        // Pad0 sequence; inputs applied before an edge, expectations after it.
        vecs[0]  = mk(1, 1, 1, 1, 1, 0, 0);
        vecs[1]  = mk(1, 1, 1, 1, 1, 0, 0);
        vecs[2]  = mk(1, 1, 0, 1, 1, 0, 1);
        vecs[3]  = mk(1, 0, 0, 0, 1, 0, 1);
        vecs[4]  = mk(1, 1, 0, 1, 1, 0, 1);
        vecs[5]  = mk(0, 1, 1, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 1, 0, 0, 1, 0);
        vecs[8]  = mk(1, 0, 1, 0, 1, 0, 0);
        vecs[9]  = mk(1, 0, 1, 0, 1, 0, 0);
        vecs[10] = mk(1, 1, 0, 1, 1, 0, 1);
        vecs[11] = mk(0, 1, 1, 0, 0, 0, 0);
        vecs[12] = mk(1, 1, 1, 0, 0, 0, 0);
        vecs[13] = mk(1, 0, 1, 0, 0, 1, 0);
        vecs[14] = mk(1, 0, 1, 0, 1, 0, 0);
        vecs[15] = mk(0, 0, 1, 0, 0, 1, 0);

        rst_ni     = 1'b0;
        dir_req_i  = '0;
        out_val_i  = '0;
        cfg_puen_i = '0;
        cfg_drv_i  = '0;
        cfg_slw_i  = '0;
        cfg_smt_i  = '0;
        pad_o_i    = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check("rst_oen",   pad_oen_o,  32'hFF);
        check("rst_pad_i", pad_i_o,    32'h00);
        check("rst_inval", in_val_o,   32'h00);
        check("rst_valid", in_valid_o, 32'hFF);
        check("rst_ack",   dir_ack_o,  32'h00);
        check("rst_edges", {rise_o, fall_o}, 32'h0);
        check("rst_cfg",   {pad_puen_o, pad_slw_o, pad_smt_o}, 32'h0);

        // Config pass-through via scoreboard.
        for (int i = 0; i < 8; i++) begin
            c.puen = 8'($urandom);
            c.drv  = 16'($urandom);
            c.slw  = 8'($urandom);
            c.smt  = 8'($urandom);
            cfg_puen_i = c.puen;
            cfg_drv_i  = c.drv;
            cfg_slw_i  = c.slw;
            cfg_smt_i  = c.smt;
            sb_q.push_back(c);
            tick();
            e = sb_q.pop_front();
            check("cfg_puen", pad_puen_o, e.puen);
            check("cfg_drv",  pad_drv_o,  e.drv);
            check("cfg_slw",  pad_slw_o,  e.slw);
            check("cfg_smt",  pad_smt_o,  e.smt);
        end

        // Pad0 direction table; other pads must stay idle in IN.
        for (int i = 0; i < 16; i++) begin
            dir_req_i = vecs[i].dir;
            out_val_i = vecs[i].val;
            tick();
            check($sformatf("tbl%0d_oen", i),   pad_oen_o,  vecs[i].oen);
            check($sformatf("tbl%0d_valid", i), in_valid_o, vecs[i].valid);
            check($sformatf("tbl%0d_ack", i),   dir_ack_o,  vecs[i].ack);
            if (vecs[i].chk_pi)
                check($sformatf("tbl%0d_pad_i", i), pad_i_o, vecs[i].pi);
        end
        dir_req_i = '0;
        out_val_i = '0;
        tick();

        // Turnaround abort on pad1.
        dir_req_i[1] = 1'b1;
        tick();
        check("abort_turn_oen",   pad_oen_o[1],  1);
        check("abort_turn_valid", in_valid_o[1], 0);
        dir_req_i[1] = 1'b0;
        tick();
        check("abort_back_oen",   pad_oen_o[1],  1);
        check("abort_back_valid", in_valid_o[1], 1);
        tick();
        check("abort_idle_oen",   pad_oen_o[1],  1);
        check("abort_idle_ack",   dir_ack_o[1],  0);

        // Two-cycle glitch on pad2 is rejected.
        pad_o_i[2] = 1'b1;
        any = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 2) begin
                tick();
                pad_o_i[2] = 1'b0;
            end else begin
                tick();
            end
            if (in_val_o[2] || rise_o[2]) any = 1;
        end
        check("glitch_rejected", any, 0);

        // Sustained high, then low: change visible exactly 5 edges later.
        pad_o_i[2] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("rise_k%0d_inval", k), in_val_o[2], (k >= 5));
            check($sformatf("rise_k%0d_pulse", k), rise_o[2],   (k == 5));
        end
        pad_o_i[2] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("fall_k%0d_inval", k), in_val_o[2], (k < 5));
            check($sformatf("fall_k%0d_pulse", k), fall_o[2],   (k == 5));
        end

        // Edge suppression while pad3 drives.
        dir_req_i[3] = 1'b1;
        repeat (4) tick();
        check("supp_ack", dir_ack_o[3], 1);
        pad_o_i[3] = 1'b1;
        any = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rise_o[3] || fall_o[3]) any = 1;
        end
        check("supp_no_rise",  any, 0);
        check("supp_inval_hi", in_val_o[3], 1);
        pad_o_i[3] = 1'b0;
        any = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rise_o[3] || fall_o[3]) any = 1;
        end
        check("supp_no_fall",  any, 0);
        check("supp_inval_lo", in_val_o[3], 0);
        pad_o_i[3]   = 1'b1;
        dir_req_i[3] = 1'b0;
        any = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rise_o[3]) any = 1;
        end
        check("post_turn_rise",  any, 1);
        check("post_turn_inval", in_val_o[3], 1);
        check("post_turn_valid", in_valid_o[3], 1);
        check("post_turn_oen",   pad_oen_o[3], 1);

        // Async reset with pads 0 and 5 driving.
        dir_req_i = 8'h21;
        repeat (4) tick();
        check("pre_rst_oen", pad_oen_o, 32'hDE);
        check("pre_rst_ack", dir_ack_o, 32'h21);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_oen",   pad_oen_o,  32'hFF);
        check("async_rst_ack",   dir_ack_o,  32'h00);
        check("async_rst_valid", in_valid_o, 32'hFF);
        dir_req_i = '0;
        pad_o_i   = '0;
        #3;
        rst_ni = 1'b1;
        tick();
        check("post_rst_oen",   pad_oen_o, 32'hFF);
        check("post_rst_inval", in_val_o,  32'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
